// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin grant sequencer.
package rr_pkg;

   typedef enum logic {IDLE, BUSY} rr_state_t;

   localparam int unsigned RR_N_REQ    = 4;
   localparam int unsigned RR_MAX_HOLD = 8;

   // Binary index of the highest set bit; 0 for an all-zero vector.
   function automatic int unsigned onehot_to_idx(input logic [31:0] v);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

   function automatic logic is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority winner select: first set req bit at or above the pointer, wrapping.
module rr_pick
   import rr_pkg::*;
#(
   parameter int unsigned N_REQ = RR_N_REQ
) (
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] prio_ptr,
   output logic [N_REQ-1:0] winner
);

   localparam int unsigned W2 = 2 * N_REQ;

   logic [W2-1:0] dbl;
   logic [W2-1:0] mask;
   logic [W2-1:0] masked;
   logic [W2-1:0] low;

   // Upper copy of req supplies the wrapped-around candidates below the pointer.
   always_comb begin
      dbl    = {req, req};
      mask   = ~({{N_REQ{1'b0}}, prio_ptr} - W2'(1));
      masked = dbl & mask;
      low    = masked & (~masked + W2'(1));
      winner = low[N_REQ-1:0] | low[W2-1:N_REQ];
   end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin grant sequencer with hold timeout; PRIORITY_LOAD_EN adds a
// loadable priority pointer (load/ptr_in ports).
module rr_grant_sequencer
   import rr_pkg::*;
#(
   parameter int unsigned N_REQ    = RR_N_REQ,
   parameter int unsigned MAX_HOLD = RR_MAX_HOLD,
   parameter int unsigned IDX_W    = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
`ifdef PRIORITY_LOAD_EN
   input  logic             load,
   input  logic [N_REQ-1:0] ptr_in,
`endif
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             busy,
   output logic             timeout,
   output logic [N_REQ-1:0] prio_ptr
);

   localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

   rr_state_t         state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [N_REQ-1:0]  winner;
   logic              hold_expired;
   logic              withdrawn;
   logic              release_now;
   logic              forced;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req      (req),
      .prio_ptr (prio_ptr),
      .winner   (winner)
   );

   // Done beats the hold expiry; a withdrawn request releases silently.
   always_comb begin
      hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
      withdrawn    = ((req & grant) == '0);
      release_now  = done || hold_expired || withdrawn;
      forced       = hold_expired && !done && !withdrawn;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         grant     <= '0;
         grant_idx <= '0;
         busy      <= 1'b0;
         timeout   <= 1'b0;
         prio_ptr  <= N_REQ'(1);
         hold_cnt  <= '0;
      end else begin
         timeout <= 1'b0;
         if (state == IDLE) begin
            if (req != '0) begin
               state     <= BUSY;
               grant     <= winner;
               grant_idx <= IDX_W'(onehot_to_idx(32'(winner)));
               busy      <= 1'b1;
               hold_cnt  <= '0;
            end
         end else begin
            if (release_now) begin
               state     <= IDLE;
               grant     <= '0;
               grant_idx <= '0;
               busy      <= 1'b0;
               hold_cnt  <= '0;
               timeout   <= forced;
               prio_ptr  <= {grant[N_REQ-2:0], grant[N_REQ-1]};
            end else begin
               hold_cnt <= hold_cnt + HOLD_W'(1);
            end
         end
`ifdef PRIORITY_LOAD_EN
         // A valid load overrides the rotate on the same edge.
         if (load && is_onehot(32'(ptr_in))) begin
            prio_ptr <= ptr_in;
         end
`endif
      end
   end

endmodule
